// File: rtl/pipe2_arbiter.sv
// Two-requester round-robin arbiter feeding a shared two-stage, tagged data pipeline.
// Build option: define PIPE2_FIXED_PRIO_EN to give requester A fixed priority over B.
module pipe2_arbiter #(
  parameter int unsigned DW    = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [DW-1:0]    din_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [DW-1:0]    din_b,
  output logic             gnt_b,
  output logic [DW-1:0]    stage1_data,
  output logic             stage1_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  output logic             out_tag,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0]    s1_data_q, s1_data_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_tag_q, s1_tag_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_tag_q, out_tag_d;
  logic             last_grant_q, last_grant_d;  // 0 = A, 1 = B
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic             adv1, adv2;

  always_comb begin
    adv2 = !out_valid_q || out_ready;
    adv1 = !s1_valid_q || adv2;
  end

  // Grant is held off in reset and whenever stage1 cannot take a word.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst && adv1) begin
      if (req_a && req_b) begin
`ifdef PIPE2_FIXED_PRIO_EN
        gnt_a = 1'b1;
`else
        gnt_a = last_grant_q;
        gnt_b = !last_grant_q;
`endif
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_comb begin
    s1_data_d    = s1_data_q;
    s1_valid_d   = s1_valid_q;
    s1_tag_d     = s1_tag_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    last_grant_d = last_grant_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;

    if (adv2) begin
      out_data_d  = s1_data_q;
      out_tag_d   = s1_tag_q;
      out_valid_d = s1_valid_q;
    end

    // Stage1 keeps its old data on an empty load; only the valid bit matters then.
    if (adv1) begin
      s1_valid_d = gnt_a || gnt_b;
      if (gnt_a) begin
        s1_data_d = din_a;
        s1_tag_d  = 1'b0;
      end else if (gnt_b) begin
        s1_data_d = din_b;
        s1_tag_d  = 1'b1;
      end
    end

    if (gnt_a) begin
      last_grant_d = 1'b0;
      if (cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNT_W'(1);
    end
    if (gnt_b) begin
      last_grant_d = 1'b1;
      if (cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_tag_q    <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      s1_data_q    <= s1_data_d;
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      last_grant_q <= last_grant_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
    end
  end

  assign stage1_data  = s1_data_q;
  assign stage1_valid = s1_valid_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_tag      = out_tag_q;
  assign busy         = s1_valid_q || out_valid_q;
  assign cnt_a        = cnt_a_q;
  assign cnt_b        = cnt_b_q;

endmodule

// File: tb/tb_pipe2_arbiter.sv
// Scoreboard bench for pipe2_arbiter: directed scenarios plus randomized traffic against
// a queue-based model of words in flight.
module tb_pipe2_arbiter;

  localparam int unsigned DW      = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_SAT = (1 << CNT_W) - 1;
`ifdef PIPE2_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [DW-1:0]    din_a = '0, din_b = '0;
  logic             gnt_a, gnt_b;
  logic [DW-1:0]    stage1_data, out_data;
  logic             stage1_valid, out_valid, out_tag;
  logic             out_ready = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  pipe2_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .din_a(din_a), .gnt_a(gnt_a),
    .req_b(req_b), .din_b(din_b), .gnt_b(gnt_b),
    .stage1_data(stage1_data), .stage1_valid(stage1_valid),
    .out_data(out_data), .out_valid(out_valid), .out_tag(out_tag),
    .out_ready(out_ready), .busy(busy),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words accepted but not yet consumed, oldest first, as {tag, data}.
  logic [DW:0] sb_q[$];
  int unsigned m_cnt_a, m_cnt_b;
  bit          m_last_b;
  bit          g_a_seen, g_b_seen;
  bit          e_a, e_b, e_adv1;
  logic [DW:0] e_word;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_cnt_a  = 0;
      m_cnt_b  = 0;
      m_last_b = 1'b1;
      g_a_seen = 1'b0;
      g_b_seen = 1'b0;
    end else begin
      // Stage1 is blocked only when two words are in flight and the consumer stalls.
      e_adv1 = !(sb_q.size() == 2 && !out_ready);
      e_a = 1'b0;
      e_b = 1'b0;
      if (e_adv1) begin
        if (req_a && req_b) begin
          e_a = FIXED ? 1'b1 : m_last_b;
          e_b = !e_a;
        end else begin
          e_a = req_a;
          e_b = req_b;
        end
      end
      chk("gnt_a", 32'(gnt_a), 32'(e_a));
      chk("gnt_b", 32'(gnt_b), 32'(e_b));
      chk("cnt_a", 32'(cnt_a), m_cnt_a);
      chk("cnt_b", 32'(cnt_b), m_cnt_b);
      chk("valid_count", 32'(stage1_valid) + 32'(out_valid), 32'(sb_q.size()));
      chk("busy", 32'(busy), 32'(sb_q.size() != 0));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e_word = sb_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e_word[DW-1:0]));
          chk("out_tag", 32'(out_tag), 32'(e_word[DW]));
        end
      end
      if (e_a) begin
        sb_q.push_back({1'b0, din_a});
        m_last_b = 1'b0;
        if (m_cnt_a < CNT_SAT) m_cnt_a++;
      end
      if (e_b) begin
        sb_q.push_back({1'b1, din_b});
        m_last_b = 1'b1;
        if (m_cnt_b < CNT_SAT) m_cnt_b++;
      end
      g_a_seen = gnt_a;
      g_b_seen = gnt_b;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    out_ready = 1'b0;
    step();
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_valids", 32'({stage1_valid, out_valid}), 32'd0);
    chk("rst_data", 32'({stage1_data, out_data, out_tag}), 32'd0);
    chk("rst_cnts", 32'({cnt_a, cnt_b}), 32'd0);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    rst = 1'b0;
  endtask

  logic exp_tag;

  initial begin
    // First-word latency.
    do_reset();
    req_a = 1'b1; din_a = 4'd1; out_ready = 1'b1;
    #1 chk("lat_gnt_a", 32'(gnt_a), 32'd1);
    step();
    req_a = 1'b0;
    chk("lat_stage1_data", 32'(stage1_data), 32'd1);
    chk("lat_stage1_valid", 32'(stage1_valid), 32'd1);
    chk("lat_out_valid_early", 32'(out_valid), 32'd0);
    step();
    chk("lat_out_data", 32'(out_data), 32'd1);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_tag", 32'(out_tag), 32'd0);

    // Alternating grants under constant contention.
    do_reset();
    din_a = 4'd2; din_b = 4'd3; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        req_a = 1'b1; req_b = 1'b1;
        exp_tag = FIXED ? 1'b0 : 1'(i % 2);
        #1;
        chk("rr_gnt_a", 32'(gnt_a), 32'(!exp_tag));
        chk("rr_gnt_b", 32'(gnt_b), 32'(exp_tag));
      end else begin
        req_a = 1'b0; req_b = 1'b0;
      end
      step();
      if (i >= 1) begin
        exp_tag = FIXED ? 1'b0 : 1'((i - 1) % 2);
        chk("rr_out_data", 32'(out_data), exp_tag ? 32'd3 : 32'd2);
        chk("rr_out_tag", 32'(out_tag), 32'(exp_tag));
        chk("rr_out_valid", 32'(out_valid), 32'd1);
      end
    end
    chk("rr_cnt_a", 32'(cnt_a), FIXED ? 32'd4 : 32'd2);
    chk("rr_cnt_b", 32'(cnt_b), FIXED ? 32'd0 : 32'd2);

    // Full pipeline with consumer stall blocks grants.
    do_reset();
    out_ready = 1'b0;
    req_a = 1'b1; din_a = 4'd4;
    step();
    din_a = 4'd5;
    step();
    din_a = 4'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_gnt_a", 32'(gnt_a), 32'd0);
      chk("stall_out_data", 32'(out_data), 32'd4);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_gnt_a", 32'(gnt_a), 32'd1);
    chk("release_out_data", 32'(out_data), 32'd4);
    step();
    req_a = 1'b0;
    chk("release_out_5", 32'(out_data), 32'd5);
    step();
    chk("release_out_6", 32'(out_data), 32'd6);
    chk("release_out_valid", 32'(out_valid), 32'd1);

    // Asynchronous reset in the middle of a full pipeline.
    do_reset();
    out_ready = 1'b0;
    req_a = 1'b1; din_a = 4'd7;
    step();
    din_a = 4'd8;
    step();
    req_a = 1'b0;
    chk("pre_rst_full", 32'({stage1_valid, out_valid}), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valids", 32'({stage1_valid, out_valid, busy}), 32'd0);
    chk("async_rst_data", 32'({stage1_data, out_data, out_tag}), 32'd0);
    chk("async_rst_cnt_a", 32'(cnt_a), 32'd0);

    // Counter saturation.
    do_reset();
    req_b = 1'b1; din_b = 4'd0; out_ready = 1'b1;
    repeat (300) step();
    chk("sat_cnt_b", 32'(cnt_b), CNT_SAT);
    chk("sat_cnt_a", 32'(cnt_a), 32'd0);
    req_b = 1'b0;

    // Randomized traffic; requests are held until granted.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step();
      if (!req_a || g_a_seen) begin
        req_a = ($urandom_range(0, 3) != 0);
        din_a = DW'($urandom);
      end
      if (!req_b || g_b_seen) begin
        req_b = ($urandom_range(0, 3) != 0);
        din_b = DW'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
